// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
// Memory-mapped interval timer and interrupt source on the CPU peripheral bus.
// Three registers sit in a window at BASE_ADDR:
//   0x00 TH   reload value, loaded into TL on every TL overflow
//   0x04 TL   up-counter, advanced once every PRESCALE clocks while EN=1
//   0x08 TCON bit0 EN (count enable), bit1 IE (interrupt enable),
//             bit2 IS (interrupt status); bits [31:3] read as 0
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   addr      CPU data-bus byte address
//   wdata     CPU store data
//   MemWrite  store strobe, one cycle per store
//   MemRead   load strobe
//   rdata     load data (combinational), 0 unless selected and reading
//   sel       high when addr hits one of the three register offsets
//   irq       registered IE && IS, level interrupt to the CPU
//   tick      registered one-cycle pulse after every TL overflow
module timer_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        irq,
    output logic        tick
);

    localparam logic [7:0]  OFF_TH   = 8'h00;
    localparam logic [7:0]  OFF_TL   = 8'h04;
    localparam logic [7:0]  OFF_TCON = 8'h08;
    localparam logic [15:0] PS_LAST  = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        is_q, is_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        tick_q;
    logic        irq_q;

    logic        wr_th, wr_tl, wr_tcon;
    logic        count_en, inc, ovf;

    // Address decode: only the three defined offsets select the block.
    assign sel = (addr[31:8] == BASE_ADDR[31:8]) &&
                 ((addr[7:0] == OFF_TH) || (addr[7:0] == OFF_TL) ||
                  (addr[7:0] == OFF_TCON));

    assign wr_th   = sel && MemWrite && (addr[7:0] == OFF_TH);
    assign wr_tl   = sel && MemWrite && (addr[7:0] == OFF_TL);
    assign wr_tcon = sel && MemWrite && (addr[7:0] == OFF_TCON);

    // A store that clears EN stops counting on that very edge, so the
    // increment is suppressed and the prescaler goes back to 0.
    assign count_en = en_q && !(wr_tcon && !wdata[0]);
    assign inc      = count_en && (pcnt_q == PS_LAST);
    assign ovf      = inc && (tl_q == 32'hFFFF_FFFF);

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        en_d   = en_q;
        ie_d   = ie_q;
        is_d   = is_q;
        pcnt_d = 16'd0;

        if (count_en) begin
            pcnt_d = (pcnt_q == PS_LAST) ? 16'd0 : pcnt_q + 16'd1;
        end

        if (wr_th) begin
            th_d = wdata;
        end

        // A CPU store to TL beats the increment/reload; the reload reads
        // th_q so a same-cycle TH store only affects the next period.
        if (wr_tl) begin
            tl_d = wdata;
        end else if (inc) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end

        // The overflow is OR-ed into the written IS so an event landing on
        // the same edge as the ISR's TCON store is never dropped.
        if (wr_tcon) begin
            en_d = wdata[0];
            ie_d = wdata[1];
            is_d = wdata[2] | (wdata[1] & ovf);
        end else begin
            is_d = is_q | (ie_q & ovf);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            is_q   <= 1'b0;
            pcnt_q <= 16'd0;
            tick_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            is_q   <= is_d;
            pcnt_q <= pcnt_d;
            tick_q <= ovf;
            // Registered from next-state so irq tracks TCON with no
            // combinational path from the bus.
            irq_q  <= ie_d & is_d;
        end
    end

    assign tick = tick_q;
    assign irq  = irq_q;

    always_comb begin
        rdata = 32'd0;
        if (sel && MemRead) begin
            case (addr[7:0])
                OFF_TH:   rdata = th_q;
                OFF_TL:   rdata = tl_q;
                OFF_TCON: rdata = {29'd0, is_q, ie_q, en_q};
                default:  rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

    localparam logic [31:0] A_TH = 32'h4000_0000;
    localparam logic [31:0] A_TL = 32'h4000_0004;
    localparam logic [31:0] A_TC = 32'h4000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;

    logic [31:0] rdata1, rdata4;
    logic        sel1, sel4, irq1, irq4, tick1, tick4;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    timer_irq_ctrl #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .rdata(rdata1), .sel(sel1), .irq(irq1), .tick(tick1)
    );

    timer_irq_ctrl #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) u_dut4 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .rdata(rdata4), .sel(sel4), .irq(irq4), .tick(tick4)
    );

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_sel;
        logic        exp_tick;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd,
                       input logic s, input logic t, input logic i);
        vec_t v;
        v.we = we; v.re = re; v.addr = a; v.wdata = d;
        v.exp_rd = rd; v.exp_sel = s; v.exp_tick = t; v.exp_irq = i;
        vecs.push_back(v);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; MemWrite = 1'b1; MemRead = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        addr = a; wdata = 32'd0; MemWrite = 1'b0; MemRead = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_tl;
        logic        exp_tk;
        logic        saw_tick;

        // we re addr wdata | rdata sel tick irq   (PRESCALE=1 instance)
        add(1, 0, A_TH, 32'hFFFF8000, 32'h0,        1, 0, 0);
        add(1, 0, A_TL, 32'hFFFFFFFD, 32'h0,        1, 0, 0);
        add(1, 0, A_TC, 32'h3,        32'h0,        1, 0, 0);
        add(0, 1, A_TL, 32'h0,        32'hFFFFFFFD, 1, 0, 0);
        add(0, 1, A_TL, 32'h0,        32'hFFFFFFFE, 1, 0, 0);
        add(0, 1, A_TL, 32'h0,        32'hFFFFFFFF, 1, 0, 0);
        add(0, 1, A_TL, 32'h0,        32'hFFFF8000, 1, 1, 1);
        add(0, 1, A_TC, 32'h0,        32'h7,        1, 0, 1);
        add(1, 0, A_TC, 32'h1,        32'h0,        1, 0, 1);
        add(0, 1, A_TL, 32'h0,        32'hFFFF8003, 1, 0, 0);
        add(1, 0, A_TC, 32'h3,        32'h0,        1, 0, 0);
        add(0, 1, A_TC, 32'h0,        32'h3,        1, 0, 0);
        add(0, 1, A_TL, 32'h0,        32'hFFFF8006, 1, 0, 0);
        add(1, 0, A_TL, 32'hFFFFFFFE, 32'h0,        1, 0, 0);
        add(0, 1, A_TL, 32'h0,        32'hFFFFFFFE, 1, 0, 0);
        add(1, 0, A_TC, 32'h3,        32'h0,        1, 0, 0);
        add(0, 1, A_TC, 32'h0,        32'h7,        1, 1, 1);
        add(0, 1, A_TL, 32'h0,        32'hFFFF8001, 1, 0, 1);
        add(1, 0, A_TL, 32'hFFFFFFFF, 32'h0,        1, 0, 1);
        add(1, 0, A_TL, 32'h5,        32'h0,        1, 0, 1);
        add(0, 1, A_TL, 32'h0,        32'h5,        1, 1, 1);
        add(0, 1, A_TL, 32'h0,        32'h6,        1, 0, 1);
        add(1, 0, A_TL, 32'hFFFFFFFF, 32'h0,        1, 0, 1);
        add(1, 0, A_TH, 32'h12345678, 32'h0,        1, 0, 1);
        add(0, 1, A_TL, 32'h0,        32'hFFFF8000, 1, 1, 1);
        add(0, 1, A_TH, 32'h0,        32'h12345678, 1, 0, 1);
        add(0, 1, 32'h4000000C, 32'h0, 32'h0,       0, 0, 1);
        add(0, 1, 32'h40000014, 32'h0, 32'h0,       0, 0, 1);
        add(1, 0, 32'h40000014, 32'hFFFFFFFF, 32'h0, 0, 0, 1);
        add(0, 1, A_TH, 32'h0,        32'h12345678, 1, 0, 1);
        add(0, 1, A_TC, 32'h0,        32'h7,        1, 0, 1);
        add(0, 1, 32'h50000000, 32'h0, 32'h0,       0, 0, 1);

        // Reset state
        #3;
        check("reset irq1", {31'd0, irq1}, 32'd0);
        check("reset tick1", {31'd0, tick1}, 32'd0);
        check("reset irq4", {31'd0, irq4}, 32'd0);
        bus_rd(A_TC);
        #1;
        check("reset TCON", rdata1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        MemRead = 1'b0;

        // PRESCALE=4: TL steps every 4 clocks, overflow every 8, IE=0
        bus_wr(A_TH, 32'hFFFFFFFE);
        bus_wr(A_TL, 32'hFFFFFFFE);
        bus_wr(A_TC, 32'h1);
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            bus_rd(A_TL);
            #1;
            exp_tl = (((k / 4) % 2) == 1) ? 32'hFFFFFFFF : 32'hFFFFFFFE;
            exp_tk = (k > 0) && ((k % 8) == 0);
            check($sformatf("ps4 TL k=%0d", k), rdata4, exp_tl);
            check($sformatf("ps4 tick k=%0d", k), {31'd0, tick4}, {31'd0, exp_tk});
            check($sformatf("ps4 irq k=%0d", k), {31'd0, irq4}, 32'd0);
        end

        @(negedge clk);
        MemRead = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors against the PRESCALE=1 instance
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            addr = vecs[i].addr;
            wdata = vecs[i].wdata;
            MemWrite = vecs[i].we;
            MemRead = vecs[i].re;
            #1;
            check($sformatf("vec%0d rdata", i), rdata1, vecs[i].exp_rd);
            check($sformatf("vec%0d sel", i), {31'd0, sel1}, {31'd0, vecs[i].exp_sel});
            check($sformatf("vec%0d tick", i), {31'd0, tick1}, {31'd0, vecs[i].exp_tick});
            check($sformatf("vec%0d irq", i), {31'd0, irq1}, {31'd0, vecs[i].exp_irq});
        end

        // Asynchronous reset mid-count with irq high
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead = 1'b0;
        check("pre-reset irq", {31'd0, irq1}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async irq", {31'd0, irq1}, 32'd0);
        bus_rd(A_TH);
        #1 check("async TH", rdata1, 32'd0);
        bus_rd(A_TL);
        #1 check("async TL", rdata1, 32'd0);
        bus_rd(A_TC);
        #1 check("async TCON", rdata1, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_rd(A_TL);
        saw_tick = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (tick1 !== 1'b0) saw_tick = 1'b1;
            check($sformatf("post-reset TL k=%0d", k), rdata1, 32'd0);
        end
        check("post-reset no tick", {31'd0, saw_tick}, 32'd0);
        check("post-reset irq", {31'd0, irq1}, 32'd0);

        @(negedge clk);
        MemRead = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
